// File: rtl/rv32_pkg.sv
// rv32_pkg: shared rv32i definitions for the pipeline core.
// Holds the opcode/funct3 encodings used by EX-stage branch control.
// Also holds the BTB entry layout, the BHT counter reset value and a
// control-instruction classifier used by the branch predictor.
package rv32_pkg;

  typedef logic [6:0] opcode_t;
  typedef logic [2:0] funct3_t;

  localparam opcode_t OC_R      = 7'b0110011;
  localparam opcode_t OC_I      = 7'b0010011;
  localparam opcode_t OC_B      = 7'b1100011;
  localparam opcode_t OC_J      = 7'b1101111;
  localparam opcode_t OC_I_JALR = 7'b1100111;

  localparam funct3_t F3_BEQ  = 3'b000;
  localparam funct3_t F3_BNE  = 3'b001;
  localparam funct3_t F3_BLT  = 3'b100;
  localparam funct3_t F3_BGE  = 3'b101;
  localparam funct3_t F3_BLTU = 3'b110;
  localparam funct3_t F3_BGEU = 3'b111;

  // BTB entry for the core's default geometry (32-bit PC, 16 entries).
  // The predictor re-declares this layout locally so that it follows
  // its own XLEN/BTB_IDX_W parameters.
  localparam int unsigned RV_XLEN      = 32;
  localparam int unsigned RV_BTB_IDX_W = 4;
  localparam int unsigned RV_BTB_TAG_W = RV_XLEN - RV_BTB_IDX_W - 2;

  typedef struct packed {
    logic                    valid;
    logic [RV_BTB_TAG_W-1:0] tag;
    logic [RV_XLEN-1:0]      target;
    logic                    uncond;
  } btb_entry_t;

  // Weakly-not-taken value for a cnt_w-bit saturating counter
  // (01 for a 2-bit counter, 0 for a 1-bit counter).
  function automatic int unsigned bht_reset_value(input int unsigned cnt_w);
    return (32'd1 << (cnt_w - 1)) - 32'd1;
  endfunction

  function automatic logic is_ctrl(input opcode_t op);
    return (op == OC_B) || (op == OC_J) || (op == OC_I_JALR);
  endfunction

endpackage

// File: rtl/branch_resolve.sv
// branch_resolve: combinational EX-stage branch/jump resolution.
// Ports:
//   opcode_EX, funct3_EX : instruction fields in EX
//   BrEq, BrLT           : comparator results (signedness chosen upstream)
//   PCSel                : 1 when the instruction actually transfers control
module branch_resolve
  import rv32_pkg::*;
(
  input  opcode_t opcode_EX,
  input  funct3_t funct3_EX,
  input  logic    BrEq,
  input  logic    BrLT,
  output logic    PCSel
);

  always_comb begin
    PCSel = 1'b0;
    case (opcode_EX)
      OC_J, OC_I_JALR: PCSel = 1'b1;
      OC_B: begin
        case (funct3_EX)
          F3_BEQ:           PCSel = BrEq;
          F3_BNE:           PCSel = ~BrEq;
          F3_BLT, F3_BLTU:  PCSel = BrLT;
          // BrEq is OR-ed in so an equal compare always counts as >=.
          F3_BGE, F3_BGEU:  PCSel = ~BrLT | BrEq;
          default:          PCSel = 1'b0;
        endcase
      end
      default: PCSel = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: IF-stage BTB/BHT predictor plus EX-stage resolution,
// mispredict detection, table training and performance counters.
// Ports:
//   clk, rst_n                       : clock, async active-low reset
//   pc_IF -> pred_taken_IF,
//            pred_target_IF          : same-cycle prediction for fetch PC
//   valid_EX, opcode_EX, funct3_EX,
//   BrEq, BrLT, pc_EX, target_EX     : resolving instruction in EX
//   pred_taken_EX, pred_target_EX    : prediction carried down from IF
//   PCSel, mispredict_EX,
//   redirect_pc_EX                   : resolution and redirect
//   branch_cnt, mispred_cnt          : wrapping performance counters
module branch_predictor
  import rv32_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned BHT_IDX_W = 6,
  parameter int unsigned BTB_IDX_W = 4,
  parameter int unsigned CNT_W     = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pc_IF,
  output logic            pred_taken_IF,
  output logic [XLEN-1:0] pred_target_IF,
  input  logic            valid_EX,
  input  opcode_t         opcode_EX,
  input  funct3_t         funct3_EX,
  input  logic            BrEq,
  input  logic            BrLT,
  input  logic [XLEN-1:0] pc_EX,
  input  logic [XLEN-1:0] target_EX,
  input  logic            pred_taken_EX,
  input  logic [XLEN-1:0] pred_target_EX,
  output logic            PCSel,
  output logic            mispredict_EX,
  output logic [XLEN-1:0] redirect_pc_EX,
  output logic [31:0]     branch_cnt,
  output logic [31:0]     mispred_cnt
);

  localparam int unsigned BHT_N = 1 << BHT_IDX_W;
  localparam int unsigned BTB_N = 1 << BTB_IDX_W;
  localparam int unsigned TAG_W = XLEN - BTB_IDX_W - 2;
  localparam logic [CNT_W-1:0] CNT_RST = CNT_W'(bht_reset_value(CNT_W));
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  target;
    logic             uncond;
  } btb_row_t;

  btb_row_t         btb_q [BTB_N];
  btb_row_t         btb_d [BTB_N];
  logic [CNT_W-1:0] bht_q [BHT_N];
  logic [CNT_W-1:0] bht_d [BHT_N];
  logic [31:0]      branch_cnt_q, branch_cnt_d;
  logic [31:0]      mispred_cnt_q, mispred_cnt_d;

  // Word-aligned PCs: bits [1:0] never take part in indexing or tags.
  logic pc_low_unused;
  assign pc_low_unused = ^{pc_IF[1:0], pc_EX[1:0]};

  // IF-side lookup reads the registered tables only, so an EX write to
  // the same index shows up one cycle later.
  logic [BTB_IDX_W-1:0] if_btb_idx;
  logic [BHT_IDX_W-1:0] if_bht_idx;
  btb_row_t             if_entry;
  logic                 if_hit;

  assign if_btb_idx     = pc_IF[BTB_IDX_W+1:2];
  assign if_bht_idx     = pc_IF[BHT_IDX_W+1:2];
  assign if_entry       = btb_q[if_btb_idx];
  assign if_hit         = if_entry.valid && (if_entry.tag == pc_IF[XLEN-1:BTB_IDX_W+2]);
  assign pred_taken_IF  = if_hit && (if_entry.uncond || bht_q[if_bht_idx][CNT_W-1]);
  assign pred_target_IF = pred_taken_IF ? if_entry.target : '0;

  branch_resolve u_resolve (
    .opcode_EX (opcode_EX),
    .funct3_EX (funct3_EX),
    .BrEq      (BrEq),
    .BrLT      (BrLT),
    .PCSel     (PCSel)
  );

  logic [BTB_IDX_W-1:0] ex_btb_idx;
  logic [BHT_IDX_W-1:0] ex_bht_idx;
  logic [TAG_W-1:0]     ex_tag;
  btb_row_t             ex_entry;
  logic                 legal_branch;

  assign ex_btb_idx   = pc_EX[BTB_IDX_W+1:2];
  assign ex_bht_idx   = pc_EX[BHT_IDX_W+1:2];
  assign ex_tag       = pc_EX[XLEN-1:BTB_IDX_W+2];
  assign ex_entry     = btb_q[ex_btb_idx];
  assign legal_branch = (opcode_EX == OC_B) && (funct3_EX != 3'b010) && (funct3_EX != 3'b011);

  assign redirect_pc_EX = PCSel ? target_EX : pc_EX + XLEN'(4);
  assign mispredict_EX  = valid_EX &&
                          ((PCSel != pred_taken_EX) || (PCSel && (pred_target_EX != target_EX)));

  // Training and counter next-state; only a valid EX instruction changes anything.
  always_comb begin
    btb_d         = btb_q;
    bht_d         = bht_q;
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (valid_EX) begin
      if (legal_branch) begin
        if (PCSel) begin
          if (bht_q[ex_bht_idx] != CNT_MAX) bht_d[ex_bht_idx] = bht_q[ex_bht_idx] + CNT_W'(1);
        end else begin
          if (bht_q[ex_bht_idx] != '0) bht_d[ex_bht_idx] = bht_q[ex_bht_idx] - CNT_W'(1);
        end
      end
      if (PCSel) begin
        btb_d[ex_btb_idx].valid  = 1'b1;
        btb_d[ex_btb_idx].tag    = ex_tag;
        btb_d[ex_btb_idx].target = target_EX;
        btb_d[ex_btb_idx].uncond = (opcode_EX == OC_J) || (opcode_EX == OC_I_JALR);
      end else if (!is_ctrl(opcode_EX) && pred_taken_EX && ex_entry.valid &&
                   (ex_entry.tag == ex_tag)) begin
        // A non-control instruction hit in the BTB: drop the aliasing entry.
        btb_d[ex_btb_idx].valid = 1'b0;
      end
      if (is_ctrl(opcode_EX)) branch_cnt_d = branch_cnt_q + 32'd1;
      if (mispredict_EX)      mispred_cnt_d = mispred_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BTB_N; i++) btb_q[i] <= '0;
      for (int i = 0; i < BHT_N; i++) bht_q[i] <= CNT_RST;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      btb_q         <= btb_d;
      bht_q         <= bht_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed self-checking bench for branch_predictor.
// A resolution table drives every branch/jump combination, followed by
// hand-written sequences for training, retargeting, aliasing, same-cycle
// read/write, gated updates and asynchronous reset.
module tb_branch_predictor;
  import rv32_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_IF;
  logic        pred_taken_IF;
  logic [31:0] pred_target_IF;
  logic        valid_EX;
  opcode_t     opcode_EX;
  funct3_t     funct3_EX;
  logic        BrEq;
  logic        BrLT;
  logic [31:0] pc_EX;
  logic [31:0] target_EX;
  logic        pred_taken_EX;
  logic [31:0] pred_target_EX;
  logic        PCSel;
  logic        mispredict_EX;
  logic [31:0] redirect_pc_EX;
  logic [31:0] branch_cnt;
  logic [31:0] mispred_cnt;

  int tests_run = 0;
  int failures  = 0;
  int exp_branch  = 0;
  int exp_mispred = 0;

  typedef struct {
    opcode_t op;
    funct3_t f3;
    logic    eq;
    logic    lt;
    logic    exp_sel;
    string   name;
  } res_vec_t;

  res_vec_t vecs[$];

  branch_predictor dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_IF          (pc_IF),
    .pred_taken_IF  (pred_taken_IF),
    .pred_target_IF (pred_target_IF),
    .valid_EX       (valid_EX),
    .opcode_EX      (opcode_EX),
    .funct3_EX      (funct3_EX),
    .BrEq           (BrEq),
    .BrLT           (BrLT),
    .pc_EX          (pc_EX),
    .target_EX      (target_EX),
    .pred_taken_EX  (pred_taken_EX),
    .pred_target_EX (pred_target_EX),
    .PCSel          (PCSel),
    .mispredict_EX  (mispredict_EX),
    .redirect_pc_EX (redirect_pc_EX),
    .branch_cnt     (branch_cnt),
    .mispred_cnt    (mispred_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic addVec(input opcode_t op, input funct3_t f3, input logic eq, input logic lt,
                        input logic sel, input string nm);
    res_vec_t v;
    v.op = op; v.f3 = f3; v.eq = eq; v.lt = lt; v.exp_sel = sel; v.name = nm;
    vecs.push_back(v);
  endtask

  // Drive one EX instruction just after a rising edge and check the
  // combinational EX outputs at the following falling edge.
  task automatic applyStimulus(input logic v, input opcode_t op, input funct3_t f3,
                               input logic eq, input logic lt, input logic [31:0] pc,
                               input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt,
                               input logic exp_sel, input logic exp_mis,
                               input logic [31:0] exp_redir, input string nm);
    @(posedge clk); #1;
    valid_EX = v; opcode_EX = op; funct3_EX = f3; BrEq = eq; BrLT = lt;
    pc_EX = pc; target_EX = tgt; pred_taken_EX = pt; pred_target_EX = ptgt;
    @(negedge clk);
    checkOutput({nm, "_pcsel"}, {63'd0, PCSel}, {63'd0, exp_sel});
    checkOutput({nm, "_mispredict"}, {63'd0, mispredict_EX}, {63'd0, exp_mis});
    checkOutput({nm, "_redirect"}, {32'd0, redirect_pc_EX}, {32'd0, exp_redir});
    if (v) begin
      if (op == OC_B || op == OC_J || op == OC_I_JALR) exp_branch++;
      if (exp_mis) exp_mispred++;
    end
  endtask

  task automatic idleCheck(input logic [31:0] pc, input logic exp_taken,
                           input logic [31:0] exp_tgt, input string nm);
    @(posedge clk); #1;
    valid_EX = 1'b0; pred_taken_EX = 1'b0; pc_IF = pc;
    @(negedge clk);
    checkOutput({nm, "_pred_taken"}, {63'd0, pred_taken_IF}, {63'd0, exp_taken});
    checkOutput({nm, "_pred_target"}, {32'd0, pred_target_IF}, {32'd0, exp_tgt});
  endtask

  task automatic checkCounters(input string nm);
    checkOutput({nm, "_branch_cnt"}, {32'd0, branch_cnt}, 64'(exp_branch));
    checkOutput({nm, "_mispred_cnt"}, {32'd0, mispred_cnt}, 64'(exp_mispred));
  endtask

  task automatic doReset();
    valid_EX = 1'b0;
    rst_n = 1'b0;
    exp_branch = 0;
    exp_mispred = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; pc_IF = 32'h100; valid_EX = 1'b0; opcode_EX = OC_R; funct3_EX = 3'b000;
    BrEq = 1'b0; BrLT = 1'b0; pc_EX = '0; target_EX = '0; pred_taken_EX = 1'b0;
    pred_target_EX = '0;

    addVec(OC_B, F3_BEQ,  1'b0, 1'b0, 1'b0, "beq_ne");
    addVec(OC_B, F3_BEQ,  1'b1, 1'b0, 1'b1, "beq_eq");
    addVec(OC_B, F3_BNE,  1'b0, 1'b0, 1'b1, "bne_ne");
    addVec(OC_B, F3_BNE,  1'b1, 1'b0, 1'b0, "bne_eq");
    addVec(OC_B, F3_BLT,  1'b0, 1'b1, 1'b1, "blt_lt");
    addVec(OC_B, F3_BLT,  1'b0, 1'b0, 1'b0, "blt_ge");
    addVec(OC_B, F3_BGE,  1'b0, 1'b1, 1'b0, "bge_lt");
    addVec(OC_B, F3_BGE,  1'b0, 1'b0, 1'b1, "bge_gt");
    addVec(OC_B, F3_BGE,  1'b1, 1'b1, 1'b1, "bge_eq_lt");
    addVec(OC_B, F3_BLTU, 1'b0, 1'b1, 1'b1, "bltu_lt");
    addVec(OC_B, F3_BLTU, 1'b1, 1'b0, 1'b0, "bltu_eq");
    addVec(OC_B, F3_BGEU, 1'b0, 1'b1, 1'b0, "bgeu_lt");
    addVec(OC_B, F3_BGEU, 1'b1, 1'b0, 1'b1, "bgeu_eq");
    addVec(OC_J, 3'b000,  1'b0, 1'b0, 1'b1, "jal");
    addVec(OC_I_JALR, 3'b000, 1'b0, 1'b0, 1'b1, "jalr");
    addVec(OC_B, 3'b010,  1'b1, 1'b1, 1'b0, "b_f3_010");
    addVec(OC_B, 3'b011,  1'b1, 1'b0, 1'b0, "b_f3_011");
    addVec(OC_R, 3'b000,  1'b1, 1'b1, 1'b0, "op_r");
    addVec(OC_I, 3'b000,  1'b1, 1'b1, 1'b0, "op_i");

    doReset();
    idleCheck(32'h100, 1'b0, 32'h0, "reset");
    checkCounters("reset");

    // Resolution table: each vector at its own PC so tables do not collide.
    for (int i = 0; i < vecs.size(); i++) begin
      logic [31:0] pc;
      logic [31:0] tgt;
      pc  = 32'h1000 + 32'(4 * i);
      tgt = 32'h2000 + 32'(8 * i);
      applyStimulus(1'b1, vecs[i].op, vecs[i].f3, vecs[i].eq, vecs[i].lt, pc, tgt,
                    1'b0, 32'h0, vecs[i].exp_sel, vecs[i].exp_sel,
                    vecs[i].exp_sel ? tgt : pc + 32'd4, vecs[i].name);
    end
    idleCheck(32'h1004, 1'b1, 32'h2008, "tbl_beq_trained");
    idleCheck(32'h1034, 1'b1, 32'h2068, "tbl_jal_trained");
    idleCheck(32'h103C, 1'b0, 32'h0, "tbl_f3_010_no_btb");
    checkCounters("table");

    // BEQ training and saturation at 0x100.
    doReset();
    applyStimulus(1'b1, OC_B, F3_BEQ, 1'b1, 1'b0, 32'h100, 32'h140, 1'b0, 32'h0,
                  1'b1, 1'b1, 32'h140, "beq_t1");
    idleCheck(32'h100, 1'b1, 32'h140, "beq_after_t1");
    applyStimulus(1'b1, OC_B, 3'b010, 1'b1, 1'b1, 32'h100, 32'h140, 1'b0, 32'h0,
                  1'b0, 1'b0, 32'h104, "illegal_f3");
    idleCheck(32'h100, 1'b1, 32'h140, "illegal_f3_no_update");
    applyStimulus(1'b1, OC_B, F3_BEQ, 1'b1, 1'b0, 32'h100, 32'h140, 1'b1, 32'h140,
                  1'b1, 1'b0, 32'h140, "beq_t2");
    applyStimulus(1'b1, OC_B, F3_BEQ, 1'b1, 1'b0, 32'h100, 32'h140, 1'b1, 32'h140,
                  1'b1, 1'b0, 32'h140, "beq_t3");
    idleCheck(32'h100, 1'b1, 32'h140, "beq_saturated_high");
    applyStimulus(1'b1, OC_B, F3_BEQ, 1'b0, 1'b0, 32'h100, 32'h140, 1'b1, 32'h140,
                  1'b0, 1'b1, 32'h104, "beq_n1");
    idleCheck(32'h100, 1'b1, 32'h140, "beq_after_n1");
    applyStimulus(1'b1, OC_B, F3_BEQ, 1'b0, 1'b0, 32'h100, 32'h140, 1'b1, 32'h140,
                  1'b0, 1'b1, 32'h104, "beq_n2");
    idleCheck(32'h100, 1'b0, 32'h0, "beq_after_n2");
    applyStimulus(1'b1, OC_B, F3_BEQ, 1'b0, 1'b0, 32'h100, 32'h140, 1'b0, 32'h0,
                  1'b0, 1'b0, 32'h104, "beq_n3");
    applyStimulus(1'b1, OC_B, F3_BEQ, 1'b0, 1'b0, 32'h100, 32'h140, 1'b0, 32'h0,
                  1'b0, 1'b0, 32'h104, "beq_n4");
    idleCheck(32'h100, 1'b0, 32'h0, "beq_saturated_low");
    checkCounters("beq_train");

    // JALR retarget at 0x200 (shares BTB and BHT index 0 with 0x100).
    applyStimulus(1'b1, OC_I_JALR, 3'b000, 1'b0, 1'b0, 32'h200, 32'h3000, 1'b0, 32'h0,
                  1'b1, 1'b1, 32'h3000, "jalr1");
    idleCheck(32'h200, 1'b1, 32'h3000, "jalr1_pred");
    applyStimulus(1'b1, OC_I_JALR, 3'b000, 1'b0, 1'b0, 32'h200, 32'h3010, 1'b1, 32'h3000,
                  1'b1, 1'b1, 32'h3010, "jalr2");
    idleCheck(32'h200, 1'b1, 32'h3010, "jalr_retarget_uncond");
    idleCheck(32'h100, 1'b0, 32'h0, "jalr_evicts_beq");
    checkCounters("jalr");

    // Alias handling: 0x500 shares index 0 with 0x100 but not its tag.
    doReset();
    applyStimulus(1'b1, OC_B, F3_BEQ, 1'b1, 1'b0, 32'h100, 32'h140, 1'b0, 32'h0,
                  1'b1, 1'b1, 32'h140, "alias_train");
    idleCheck(32'h500, 1'b0, 32'h0, "alias_miss");
    idleCheck(32'h100, 1'b1, 32'h140, "alias_base_hit");
    applyStimulus(1'b1, OC_R, 3'b000, 1'b0, 1'b0, 32'h500, 32'h0, 1'b1, 32'h140,
                  1'b0, 1'b1, 32'h504, "alias_other_tag");
    idleCheck(32'h100, 1'b1, 32'h140, "alias_tag_guard");
    applyStimulus(1'b1, OC_R, 3'b000, 1'b0, 1'b0, 32'h100, 32'h0, 1'b1, 32'h140,
                  1'b0, 1'b1, 32'h104, "alias_op_r");
    idleCheck(32'h100, 1'b0, 32'h0, "alias_invalidated");
    checkCounters("alias");

    // Same-index lookup and write in one cycle: old value, then new.
    applyStimulus(1'b1, OC_J, 3'b000, 1'b0, 1'b0, 32'h100, 32'h180, 1'b0, 32'h0,
                  1'b1, 1'b1, 32'h180, "same_jal1");
    checkOutput("same_cycle_old_taken", {63'd0, pred_taken_IF}, 64'd0);
    idleCheck(32'h100, 1'b1, 32'h180, "same_next");
    applyStimulus(1'b1, OC_J, 3'b000, 1'b0, 1'b0, 32'h100, 32'h1C0, 1'b1, 32'h180,
                  1'b1, 1'b1, 32'h1C0, "same_jal2");
    checkOutput("same_cycle_old_target", {32'd0, pred_target_IF}, 64'h180);
    idleCheck(32'h100, 1'b1, 32'h1C0, "same_next2");

    // valid_EX low: no flag, no training, counters frozen.
    applyStimulus(1'b0, OC_B, F3_BEQ, 1'b1, 1'b0, 32'h100, 32'h200, 1'b0, 32'h0,
                  1'b1, 1'b0, 32'h200, "invalid_ex");
    idleCheck(32'h100, 1'b1, 32'h1C0, "invalid_no_btb");
    checkCounters("invalid_ex");

    // Asynchronous reset while an update is pending.
    applyStimulus(1'b1, OC_B, F3_BEQ, 1'b1, 1'b0, 32'h100, 32'h240, 1'b0, 32'h0,
                  1'b1, 1'b1, 32'h240, "pre_reset_upd");
    #2;
    rst_n = 1'b0;
    exp_branch = 0;
    exp_mispred = 0;
    #1;
    checkOutput("async_reset_pred", {63'd0, pred_taken_IF}, 64'd0);
    checkCounters("async_reset");
    valid_EX = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idleCheck(32'h100, 1'b0, 32'h0, "post_reset_clear");
    checkCounters("post_reset");

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
